// File: rtl/edge_evt_pkg.sv
// Shared definitions for the edge event arbiter.
//   MODE_*  : per-channel 2-bit mode encoding (off / rising / falling / both)
//   EDGE_*  : edge-type encoding carried with every event
//   edge_enabled() : decides whether a detected edge is accepted by a mode
package edge_evt_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    function automatic logic edge_enabled(input logic [1:0] mode,
                                          input logic       rise,
                                          input logic       fall);
        return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
               (fall && (mode == MODE_FALL || mode == MODE_BOTH));
    endfunction

endpackage

// File: rtl/edge_evt_ch.sv
// One trigger channel: edge detection, mode qualification and a single-entry
// pending slot holding the edge type of the oldest unserved event.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   trigger     : level input for this channel
//   mode        : 2-bit mode (off / rise / fall / both)
//   grant       : the arbiter moves this channel's event to the output now
//   pending     : an event is waiting
//   edge_type   : edge type of the waiting event (EDGE_RISE / EDGE_FALL)
//   drop        : a qualified edge is being discarded this cycle
module edge_evt_ch
    import edge_evt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic [1:0] mode,
    input  logic       grant,
    output logic       pending,
    output logic       edge_type,
    output logic       drop
);

    logic trig_q;
    logic rise_det;
    logic fall_det;
    logic qual;

    always_comb begin
        rise_det = trigger & ~trig_q;
        fall_det = ~trigger & trig_q;
        qual     = edge_enabled(mode, rise_det, fall_det);
        // The slot is only free for a new edge if it is empty or being
        // emptied by the arbiter in this same cycle.
        drop     = qual & pending & ~grant;
    end

    always_ff @(posedge clk) begin
        // trig_q tracks the input even in reset so a level already high at
        // release is not mistaken for a rising edge.
        trig_q <= trigger;
        if (!rst_n) begin
            pending   <= 1'b0;
            edge_type <= EDGE_FALL;
        end else if (mode == MODE_OFF) begin
            pending <= 1'b0;
        end else if (qual && (!pending || grant)) begin
            pending   <= 1'b1;
            edge_type <= rise_det ? EDGE_RISE : EDGE_FALL;
        end else if (grant) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event controller. Each channel detects qualified edges
// into a one-deep pending slot; a round-robin arbiter serialises pending
// events into a registered output stream and overflow is counted.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   trigger     : NUM_CH level inputs
//   mode        : 2 bits per channel, channel i at [2i+1:2i]
//   evt_valid / evt_ready / evt_ch / evt_rise : output event stream
//   pending     : per-channel pending flags (status)
//   drop_cnt    : saturating count of events lost to overflow
//
// Handshake: an event transfers on a clk edge where evt_valid && evt_ready.
// While evt_valid is high and evt_ready low, evt_ch/evt_rise stay constant
// and evt_valid stays high; evt_valid never depends combinationally on
// evt_ready.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     trigger,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CH_W-1:0]       evt_ch,
    output logic                  evt_rise,
    output logic [NUM_CH-1:0]     pending,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int               ACC_W   = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] edge_type;
    logic [NUM_CH-1:0] drops;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   next_ptr;
    logic              found;
    logic              load;
    logic [4:0]        n_drop;
    logic [ACC_W-1:0]  drop_sum;
    logic [CNT_W-1:0]  drop_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_evt_ch u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .trigger   (trigger[i]),
            .mode      (mode[2*i +: 2]),
            .grant     (grant[i]),
            .pending   (pending[i]),
            .edge_type (edge_type[i]),
            .drop      (drops[i])
        );
    end

    // Output register is free when empty or being drained this cycle.
    assign load = !evt_valid || evt_ready;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = CH_W'(idx);
            end
        end
        next_ptr = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = load && found && (winner == CH_W'(i));
        end
    end

    // Several channels can overflow in one cycle; add them all, then clamp.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_drop = n_drop + 5'(drops[i]);
        end
        drop_sum  = ACC_W'(drop_cnt) + ACC_W'(n_drop);
        drop_next = (drop_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            rr_ptr    <= '0;
            drop_cnt  <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (load) begin
                if (found) begin
                    evt_valid <= 1'b1;
                    evt_ch    <= winner;
                    evt_rise  <= edge_type[winner];
                    rr_ptr    <= next_ptr;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MX = 255;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  trigger;
    logic [7:0]  mode;
    logic        evt_ready;
    logic        evt_valid;
    logic [1:0]  evt_ch;
    logic        evt_rise;
    logic [3:0]  pending;
    logic [7:0]  drop_cnt;

    // Second instance with a 2-bit drop counter for the saturation check.
    logic [3:0]  s_trigger;
    logic [7:0]  s_mode;
    logic        s_ready;
    logic        s_valid;
    logic [1:0]  s_ch;
    logic        s_rise;
    logic [3:0]  s_pending;
    logic [1:0]  s_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .mode      (mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (s_trigger),
        .mode      (s_mode),
        .evt_valid (s_valid),
        .evt_ready (s_ready),
        .evt_ch    (s_ch),
        .evt_rise  (s_rise),
        .pending   (s_pending),
        .drop_cnt  (s_drop_cnt)
    );

    // ---------------- reference model ----------------
    // Each channel is a one-slot mailbox; the output is a one-slot mailbox;
    // the arbiter scans slots from the pointer with modulo arithmetic.
    int m_prev [NUM_CH];
    int m_pend [NUM_CH];
    int m_type [NUM_CH];
    int m_rr, m_valid, m_ch, m_rise, m_drop;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_prev[c] = int'(trigger[c]);
                m_pend[c] = 0;
                m_type[c] = 0;
            end
            m_rr = 0; m_valid = 0; m_ch = 0; m_rise = 0; m_drop = 0;
        end else begin : model_step
            int g;
            int md;
            int r, f, hit;
            g = -1;
            if (m_valid == 0 || evt_ready) begin
                for (int off = 0; off < NUM_CH; off++)
                    if (g < 0 && m_pend[(m_rr + off) % NUM_CH] != 0) g = (m_rr + off) % NUM_CH;
                if (g >= 0) begin
                    m_valid = 1; m_ch = g; m_rise = m_type[g]; m_rr = (g + 1) % NUM_CH;
                end else begin
                    m_valid = 0;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                md  = int'(mode[2*c +: 2]);
                r   = (trigger[c] && m_prev[c] == 0) ? 1 : 0;
                f   = (!trigger[c] && m_prev[c] != 0) ? 1 : 0;
                hit = ((r != 0 && (md == 1 || md == 3)) || (f != 0 && (md == 2 || md == 3))) ? 1 : 0;
                if (md == 0) begin
                    m_pend[c] = 0;
                end else if (hit != 0) begin
                    if (m_pend[c] != 0 && g != c) begin
                        if (m_drop < CNT_MX) m_drop = m_drop + 1;
                    end else begin
                        m_pend[c] = 1;
                        m_type[c] = r;
                    end
                end else if (g == c) begin
                    m_pend[c] = 0;
                end
                m_prev[c] = int'(trigger[c]);
            end
        end
    end

    // Inputs change at negedge; outputs are read at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trigger = 4'hF; mode = 8'hFF; evt_ready = 1'b1;
        s_trigger = 4'h0; s_mode = 8'h00; s_ready = 1'b0;
        step(); step();
        n_tests++;
        if ({evt_valid, evt_ch, evt_rise} !== 4'b0) begin
            n_fail++; $display("FAIL reset_out: got v=%0b ch=%0d r=%0b, want 0/0/0", evt_valid, evt_ch, evt_rise);
        end
        n_tests++;
        if (pending !== 4'h0) begin
            n_fail++; $display("FAIL reset_pending: got %b, want 0000", pending);
        end
        n_tests++;
        if (drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_drop: got %0d, want 0", drop_cnt);
        end
        rst_n = 1'b1;
        repeat (5) begin
            step();
            n_tests++;
            if (evt_valid !== 1'b0 || pending !== 4'h0) begin
                n_fail++; $display("FAIL reset_release_quiet: got v=%0b pend=%b, want 0/0000", evt_valid, pending);
            end
        end
    endtask

    task automatic test_single_rise();
        mode = 8'h00; trigger = 4'h0;
        step(); step();
        mode = 8'b0000_0100;
        step();
        trigger = 4'b0010;
        step();
        n_tests++;
        if (pending !== 4'b0010 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pending: got pend=%b v=%0b, want 0010/0", pending, evt_valid);
        end
        step();
        n_tests++;
        if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b1} || pending !== 4'h0) begin
            n_fail++; $display("FAIL single_event: got v=%0b ch=%0d r=%0b pend=%b, want 1/1/1/0000",
                               evt_valid, evt_ch, evt_rise, pending);
        end
        step();
        n_tests++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_one_cycle: got v=%0b, want 0", evt_valid);
        end
        trigger = 4'b0000;
        repeat (3) begin
            step();
            n_tests++;
            if (evt_valid !== 1'b0 || pending !== 4'h0) begin
                n_fail++; $display("FAIL single_fall_ignored: got v=%0b pend=%b, want 0/0000", evt_valid, pending);
            end
        end
    endtask

    task automatic test_burst();
        logic [3:0] ep;
        rst_n = 1'b0; mode = 8'hFF; trigger = 4'h0; evt_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        for (int b = 0; b < 3; b++) begin
            // bursts: all rise, all fall, all rise again
            trigger = (b == 1) ? 4'h0 : 4'hF;
            step();
            n_tests++;
            if (pending !== 4'hF || evt_valid !== 1'b0) begin
                n_fail++; $display("FAIL burst%0d_pending: got pend=%b v=%0b, want 1111/0", b, pending, evt_valid);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                step();
                ep = 4'hF << (i + 1);
                n_tests++;
                if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'(i), (b != 1)} || pending !== ep) begin
                    n_fail++; $display("FAIL burst%0d_evt%0d: got v=%0b ch=%0d r=%0b pend=%b, want 1/%0d/%0b/%b",
                                       b, i, evt_valid, evt_ch, evt_rise, pending, i, (b != 1), ep);
                end
            end
            step();
            n_tests++;
            if (evt_valid !== 1'b0) begin
                n_fail++; $display("FAIL burst%0d_drained: got v=%0b, want 0", b, evt_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; mode = 8'b0011_0000; trigger = 4'h0; evt_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        trigger = 4'b0100;
        step();
        n_tests++;
        if (pending !== 4'b0100 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_first_pending: got pend=%b v=%0b, want 0100/0", pending, evt_valid);
        end
        // fall arrives as the rise moves out: slot refills
        trigger = 4'b0000;
        step();
        n_tests++;
        if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b1} || pending !== 4'b0100 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL bp_loaded: got v=%0b ch=%0d r=%0b pend=%b drop=%0d, want 1/2/1/0100/0",
                               evt_valid, evt_ch, evt_rise, pending, drop_cnt);
        end
        for (int k = 1; k <= 2; k++) begin
            trigger = (k == 1) ? 4'b0100 : 4'b0000;
            step();
            n_tests++;
            if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b1} || pending !== 4'b0100 || drop_cnt !== 8'(k)) begin
                n_fail++; $display("FAIL bp_drop%0d: got v=%0b ch=%0d r=%0b pend=%b drop=%0d, want 1/2/1/0100/%0d",
                                   k, evt_valid, evt_ch, evt_rise, pending, drop_cnt, k);
            end
        end
        evt_ready = 1'b1;
        step();
        n_tests++;
        if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b0} || pending !== 4'h0) begin
            n_fail++; $display("FAIL bp_second_event: got v=%0b ch=%0d r=%0b pend=%b, want 1/2/0/0000",
                               evt_valid, evt_ch, evt_rise, pending);
        end
        step();
        n_tests++;
        if (evt_valid !== 1'b0 || drop_cnt !== 8'd2) begin
            n_fail++; $display("FAIL bp_drained: got v=%0b drop=%0d, want 0/2", evt_valid, drop_cnt);
        end
    endtask

    task automatic test_mode_off();
        rst_n = 1'b0; mode = 8'h03; trigger = 4'h0; evt_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        trigger = 4'b0001;
        step();
        trigger = 4'b0000;
        step();
        n_tests++;
        if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1} || pending !== 4'b0001) begin
            n_fail++; $display("FAIL off_setup: got v=%0b ch=%0d r=%0b pend=%b, want 1/0/1/0001",
                               evt_valid, evt_ch, evt_rise, pending);
        end
        mode = 8'h00;
        step();
        n_tests++;
        if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1} || pending !== 4'b0000) begin
            n_fail++; $display("FAIL off_clears: got v=%0b ch=%0d r=%0b pend=%b, want 1/0/1/0000",
                               evt_valid, evt_ch, evt_rise, pending);
        end
        evt_ready = 1'b1;
        step();
        n_tests++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL off_delivered: got v=%0b, want 0", evt_valid);
        end
    endtask

    task automatic test_saturate();
        int exp_d;
        rst_n = 1'b0; s_mode = 8'h03; s_trigger = 4'h0; s_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        // first edge fills the slot, second refills it as the first loads,
        // the remaining five all overflow
        for (int n = 1; n <= 7; n++) begin
            s_trigger = {3'b000, ~s_trigger[0]};
            step();
            exp_d = (n <= 2) ? 0 : ((n - 2 > 3) ? 3 : n - 2);
            n_tests++;
            if (s_drop_cnt !== 2'(exp_d)) begin
                n_fail++; $display("FAIL sat_drop_n%0d: got %0d, want %0d", n, s_drop_cnt, exp_d);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] mp;
        rst_n = 1'b0; evt_ready = 1'b0; trigger = 4'h0; mode = 8'hFF;
        step();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) mode = 8'($urandom);
            if ($urandom_range(0, 2) == 0) trigger = 4'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 699) != 0);
            step();
            for (int c = 0; c < NUM_CH; c++) mp[c] = (m_pend[c] != 0);
            n_tests++;
            if (evt_valid !== 1'(m_valid) || (m_valid != 0 && (evt_ch !== 2'(m_ch) || evt_rise !== 1'(m_rise)))) begin
                n_fail++; $display("FAIL rand_out cyc%0d: got v=%0b ch=%0d r=%0b, want %0d/%0d/%0d",
                                   cyc, evt_valid, evt_ch, evt_rise, m_valid, m_ch, m_rise);
            end
            n_tests++;
            if (pending !== mp || drop_cnt !== 8'(m_drop)) begin
                n_fail++; $display("FAIL rand_status cyc%0d: got pend=%b drop=%0d, want %b/%0d",
                                   cyc, pending, drop_cnt, mp, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_burst();
        test_backpressure();
        test_mode_off();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
